ascon_stream_ctrl: RTL
======================

Name: ascon_stream_ctrl

Overview:
- Sequencer that drives one ascon core through init, associated data (AD), plaintext streaming and finalisation.
- Plaintext enters as a 64-bit valid/ready stream; ciphertext leaves as a 64-bit valid/ready stream. The 128-bit tag is latched at the end.
- Replaces wide fixed-size plaintext buses in the top level. Handles variable message lengths and downstream backpressure.

Parameters:
- CNT_W, 5, width of the block-count inputs (max 2^CNT_W-1 blocks per phase)
- BLK_W, 64, rate block width (fixed to 64; kept as a parameter for the package constant)

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  asynchronous, active-low reset
- start_i  in  1  start pulse; sampled in S_IDLE only
- nb_ad_blocks_i  in  CNT_W  AD block count, sampled at start (0 = no AD)
- nb_pt_blocks_i  in  CNT_W  plaintext block count, sampled at start (must be >=1)
- ad_data_i  in  BLK_W  AD word; must be stable while ad_ready_o=1
- ad_valid_i  in  1  AD word valid
- ad_ready_o  out  1  AD word accepted when valid&ready
- pt_data_i  in  BLK_W  plaintext word
- pt_valid_i  in  1  plaintext valid
- pt_ready_o  out  1  plaintext accepted when valid&ready
- ct_data_o  out  BLK_W  ciphertext word (registered)
- ct_valid_o  out  1  ciphertext valid
- ct_ready_i  in  1  ciphertext consumed when valid&ready
- tag_o  out  128  tag, registered; held until the next start
- busy_o  out  1  high in every state except S_IDLE
- done_o  out  1  one-cycle pulse when the tag is latched
- err_o  out  1  one-cycle pulse on a rejected start
- init_o, associate_data_o, finalisation_o  out  1  core mode levels
- data_o  out  BLK_W  core data
- data_valid_o  out  1  core data strobe (one cycle per block)
- end_initialisation_i, end_associate_i, cipher_valid_i, end_cipher_i, end_tag_i  in  1  core status strobes
- cipher_i  in  BLK_W  core ciphertext
- tag_i  in  128  core tag

Behaviour:
- Reset (reset_i=0, asynchronous): state S_IDLE; all outputs 0, including tag_o, ct_data_o and the counters.
- S_IDLE: on start_i=1:
  - if nb_pt_blocks_i=0: pulse err_o next cycle and stay in S_IDLE;
  - otherwise latch both counts, clear the block counter, go to S_INIT.
  - start_i in any other state is ignored.
- S_INIT: init_o=1. On end_initialisation_i: go to S_AD_WAIT_IN if the AD count is >0, else S_PT_WAIT_IN.
- S_AD_WAIT_IN: associate_data_o=1, ad_ready_o=1. On handshake: data_o<=ad_data_i, data_valid_o=1 for exactly the next cycle, go to S_AD_WAIT_CORE.
- S_AD_WAIT_CORE: associate_data_o=1. On end_associate_i, increment the counter:
  - if counter = AD count: clear the counter, go to S_PT_WAIT_IN;
  - else go to S_AD_WAIT_IN.
- S_PT_WAIT_IN: pt_ready_o=1 only when ct_valid_o=0, so one output word is buffered at most.
  - Handshake on the last block (counter = PT count-1): go to S_FIN_SEND.
  - Handshake on any other block: go to S_PT_SEND.
  - Register the accepted word in both cases.
- S_PT_SEND: data_valid_o=1 for one cycle, then S_PT_WAIT_CIPH.
- S_PT_WAIT_CIPH: on cipher_valid_i, ct_data_o<=cipher_i and ct_valid_o<=1, then S_PT_WAIT_END. If end_cipher_i arrives in the same cycle, go straight to S_PT_WAIT_IN.
- S_PT_WAIT_END: on end_cipher_i, increment the counter, go to S_PT_WAIT_IN.
- S_FIN_SEND: finalisation_o=1, data_valid_o=1 for one cycle, then S_FIN_WAIT.
- S_FIN_WAIT: finalisation_o=1.
  - cipher_valid_i captures the last ciphertext word.
  - end_tag_i latches tag_o and goes to S_DONE. If end_tag_i precedes cipher_valid_i, keep waiting for both.
- S_DONE: done_o=1 for one cycle, go to S_IDLE. A pending ct word stays valid until consumed.
- ct_valid_o clears on ct_valid_o&ct_ready_i.
  - Capture has priority: if capture and consume coincide, the new word is held and ct_valid_o stays 1.
  - A core strobe that arrives while ct_valid_o=1 cannot occur by construction, because the next block is not accepted until the buffer is empty.
- Core strobes outside their waiting state are ignored.
- Reset mid-operation aborts the run immediately with no flush. The core shares the reset.
- Counters are CNT_W bits and never wrap, since the latched counts are at most 2^CNT_W-1.

Decomposition:
- Package ascon_pkg holds:
  - the state enum type ascon_ctrl_state_t;
  - localparams ASCON_BLK_W=64 and ASCON_TAG_W=128.
- One sub-module: the block counter uses the existing compteur_Nbits (N_bits=CNT_W) with en/init driven by the FSM.

Test Plan:
- AD=1 (0x0001020304050607), PT=3, ct_ready_i=1, behavioural core with 12-cycle permutation:
  - exactly 1 AD strobe, then 3 data_valid_o pulses with finalisation_o=1 only on the 3rd;
  - 3 ct words in order;
  - tag_o equals the model tag;
  - done_o pulses once.
- nb_ad_blocks_i=0, PT=1: no associate_data_o at all; S_INIT goes straight to the PT phase; the single block is sent with finalisation.
- PT=4, ct_ready_i held 0 for 20 cycles after the first ct word:
  - pt_ready_o stays 0 and no data_valid_o occurs;
  - after release, the remaining 3 words follow and no word is lost.
- start_i pulsed during the PT phase: ignored, with counts unchanged. Then start with nb_pt_blocks_i=0 from S_IDLE: err_o pulses 1 cycle and busy_o stays 0.
- reset_i driven low asynchronously mid-S_PT_WAIT_CIPH: all outputs 0 immediately, state S_IDLE. A subsequent full run (AD=1, PT=2) completes correctly.
- cipher_valid_i and end_cipher_i in the same cycle, with ct_ready_i=1 in that cycle: the word is captured, the FSM goes to S_PT_WAIT_IN, and ct_valid_o is held high for that word.

Source files
------------

// File: rtl/ascon_pkg.sv
// ascon_pkg: shared widths and sequencer state type for the ascon stream controller
package ascon_pkg;
  localparam int ASCON_BLK_W = 64;
  localparam int ASCON_TAG_W = 128;
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_AD_WAIT_IN, S_AD_WAIT_CORE, S_PT_WAIT_IN, S_PT_SEND,
    S_PT_WAIT_CIPH, S_PT_WAIT_END, S_FIN_SEND, S_FIN_WAIT, S_DONE
  } ascon_ctrl_state_t;
endpackage

// File: rtl/ascon_stream_ctrl_compteur.sv
// compteur_Nbits: block counter with synchronous clear (priority over enable)
module compteur_Nbits #(
  parameter int N_bits = 5
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              init_i,
  input  logic              en_i,
  output logic [N_bits-1:0] cpt_o
);
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) cpt_o <= '0;
    else if (init_i) cpt_o <= '0;
    else if (en_i) cpt_o <= cpt_o + 1'b1;
endmodule

// File: rtl/ascon_stream_ctrl.sv
// ascon_stream_ctrl: sequences one ascon core through init, AD, streamed plaintext and finalisation
module ascon_stream_ctrl import ascon_pkg::*; #(
  parameter int CNT_W = 5,
  parameter int BLK_W = ASCON_BLK_W
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [CNT_W-1:0]       nb_ad_blocks_i,
  input  logic [CNT_W-1:0]       nb_pt_blocks_i,
  input  logic [BLK_W-1:0]       ad_data_i,
  input  logic                   ad_valid_i,
  output logic                   ad_ready_o,
  input  logic [BLK_W-1:0]       pt_data_i,
  input  logic                   pt_valid_i,
  output logic                   pt_ready_o,
  output logic [BLK_W-1:0]       ct_data_o,
  output logic                   ct_valid_o,
  input  logic                   ct_ready_i,
  output logic [ASCON_TAG_W-1:0] tag_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   init_o,
  output logic                   associate_data_o,
  output logic                   finalisation_o,
  output logic [BLK_W-1:0]       data_o,
  output logic                   data_valid_o,
  input  logic                   end_initialisation_i,
  input  logic                   end_associate_i,
  input  logic                   cipher_valid_i,
  input  logic                   end_cipher_i,
  input  logic                   end_tag_i,
  input  logic [BLK_W-1:0]       cipher_i,
  input  logic [ASCON_TAG_W-1:0] tag_i
);
  ascon_ctrl_state_t state;
  logic [CNT_W-1:0] nb_ad, nb_pt, cnt;
  logic [CNT_W:0] cnt_nx;
  logic start_ok, ad_last, pt_last, ct_cap, cnt_en, cnt_init, ct_seen, tag_seen, fin_done;
  assign start_ok = state == S_IDLE && start_i && nb_pt_blocks_i != '0;
  assign ad_ready_o = state == S_AD_WAIT_IN;
  assign pt_ready_o = state == S_PT_WAIT_IN && !ct_valid_o;
  assign busy_o = state != S_IDLE;
  assign init_o = state == S_INIT;
  assign associate_data_o = state == S_AD_WAIT_IN || state == S_AD_WAIT_CORE;
  assign finalisation_o = state == S_FIN_SEND || state == S_FIN_WAIT;
  // cnt_nx compares the post-increment count against the latched totals without wrapping
  assign cnt_nx = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign ad_last = cnt_nx == {1'b0, nb_ad};
  assign pt_last = cnt_nx == {1'b0, nb_pt};
  assign ct_cap = cipher_valid_i && (state == S_PT_WAIT_CIPH || (state == S_FIN_WAIT && !ct_seen));
  assign fin_done = (ct_seen || cipher_valid_i) && (tag_seen || end_tag_i);
  assign cnt_en = (state == S_AD_WAIT_CORE && end_associate_i) ||
                  (state == S_PT_WAIT_CIPH && cipher_valid_i && end_cipher_i) ||
                  (state == S_PT_WAIT_END && end_cipher_i);
  assign cnt_init = start_ok || (state == S_AD_WAIT_CORE && end_associate_i && ad_last);

  compteur_Nbits #(.N_bits(CNT_W)) u_cnt (
    .clock_i(clock_i), .reset_i(reset_i), .init_i(cnt_init), .en_i(cnt_en), .cpt_o(cnt)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= S_IDLE;
      nb_ad <= '0;
      nb_pt <= '0;
      data_o <= '0;
      data_valid_o <= 1'b0;
      ct_data_o <= '0;
      ct_valid_o <= 1'b0;
      tag_o <= '0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      ct_seen <= 1'b0;
      tag_seen <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= state == S_IDLE && start_i && nb_pt_blocks_i == '0;
      // a fresh capture wins over a same-cycle consume of the previous word
      if (ct_cap) begin
        ct_data_o <= cipher_i;
        ct_valid_o <= 1'b1;
      end else if (ct_ready_i) ct_valid_o <= 1'b0;
      if (state == S_FIN_WAIT && end_tag_i && !tag_seen) tag_o <= tag_i;
      case (state)
        S_IDLE: if (start_ok) begin
          nb_ad <= nb_ad_blocks_i;
          nb_pt <= nb_pt_blocks_i;
          state <= S_INIT;
        end
        S_INIT: if (end_initialisation_i) state <= nb_ad != '0 ? S_AD_WAIT_IN : S_PT_WAIT_IN;
        S_AD_WAIT_IN: if (ad_valid_i) begin
          data_o <= ad_data_i;
          data_valid_o <= 1'b1;
          state <= S_AD_WAIT_CORE;
        end
        S_AD_WAIT_CORE: if (end_associate_i) state <= ad_last ? S_PT_WAIT_IN : S_AD_WAIT_IN;
        S_PT_WAIT_IN: if (pt_valid_i && pt_ready_o) begin
          data_o <= pt_data_i;
          data_valid_o <= 1'b1;
          ct_seen <= 1'b0;
          tag_seen <= 1'b0;
          state <= pt_last ? S_FIN_SEND : S_PT_SEND;
        end
        S_PT_SEND: state <= S_PT_WAIT_CIPH;
        S_PT_WAIT_CIPH: if (cipher_valid_i) state <= end_cipher_i ? S_PT_WAIT_IN : S_PT_WAIT_END;
        S_PT_WAIT_END: if (end_cipher_i) state <= S_PT_WAIT_IN;
        S_FIN_SEND: state <= S_FIN_WAIT;
        S_FIN_WAIT: begin
          ct_seen <= ct_seen || cipher_valid_i;
          tag_seen <= tag_seen || end_tag_i;
          done_o <= fin_done;
          if (fin_done) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
